// File: rtl/incdec_arbiter_if.sv
// Requester-side bundle for incdec_arbiter: two REQ/OP/D request channels, their ACK
// pulses, and the registered count/status outputs.
interface incdec_arbiter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             req0;
  logic             req1;
  logic [1:0]       op0;
  logic [1:0]       op1;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic             ack0;
  logic             ack1;
  logic [WIDTH-1:0] q0;
  logic [WIDTH-1:0] q1;
  logic             cout;
  logic             busy;
  logic             gnt;

  modport master (
    output req0, req1, op0, op1, d0, d1,
    input  ack0, ack1, q0, q1, cout, busy, gnt
  );

  modport slave (
    input  req0, req1, op0, op1, d0, d1,
    output ack0, ack1, q0, q1, cout, busy, gnt
  );
endinterface

// File: rtl/incdec_arbiter.sv
// Two requesters share one inc/dec adder chain. A round-robin pick in IDLE latches the
// winner's operands, EXEC writes the result back, and RESP pulses the ACK.
module incdec_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input logic             i_clk,
  input logic             i_rst,
  incdec_arbiter_if.slave bus
);

  localparam logic [1:0] OpInc  = 2'b00;
  localparam logic [1:0] OpDec  = 2'b01;
  localparam logic [1:0] OpLoad = 2'b10;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_ptr;
  logic             r_gnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_q0;
  logic [WIDTH-1:0] r_q1;
  logic             r_cout;
  logic             r_ack0;
  logic             r_ack1;

  logic             w_win;
  logic [WIDTH:0]   w_addend;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_cout;

  // r_ptr names the requester that wins a tie; a lone request always wins.
  always_comb begin
    w_win = r_ptr;
    if (bus.req0 && !bus.req1) begin
      w_win = 1'b0;
    end else if (!bus.req0 && bus.req1) begin
      w_win = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (bus.req0 || bus.req1) w_state_nxt = StExec;
      StExec:  w_state_nxt = StResp;
      StResp:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Decrement adds all-ones, so the carry-out doubles as the "no borrow" flag.
  always_comb begin
    w_addend = {{WIDTH{1'b0}}, 1'b1};
    if (r_op == OpDec) begin
      w_addend = {1'b0, {WIDTH{1'b1}}};
    end
    w_sum  = {1'b0, r_opnd} + w_addend;
    w_res  = '0;
    w_cout = 1'b0;
    case (r_op)
      OpInc, OpDec: begin
        w_res  = w_sum[WIDTH-1:0];
        w_cout = w_sum[WIDTH];
      end
      OpLoad:  w_res = r_d;
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr  <= 1'b0;
      r_gnt  <= 1'b0;
      r_op   <= OpInc;
      r_opnd <= '0;
      r_d    <= '0;
      r_q0   <= '0;
      r_q1   <= '0;
      r_cout <= 1'b0;
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        StIdle: begin
          if (bus.req0 || bus.req1) begin
            r_gnt  <= w_win;
            r_op   <= w_win ? bus.op1 : bus.op0;
            r_d    <= w_win ? bus.d1 : bus.d0;
            r_opnd <= w_win ? r_q1 : r_q0;
          end
        end
        StExec: begin
          if (r_gnt) begin
            r_q1 <= w_res;
          end else begin
            r_q0 <= w_res;
          end
          r_cout <= w_cout;
          r_ack0 <= ~r_gnt;
          r_ack1 <= r_gnt;
        end
        StResp:  r_ptr <= ~r_gnt;
        default: ;
      endcase
    end
  end

  assign bus.ack0 = r_ack0;
  assign bus.ack1 = r_ack1;
  assign bus.q0   = r_q0;
  assign bus.q1   = r_q1;
  assign bus.cout = r_cout;
  assign bus.gnt  = r_gnt;
  assign bus.busy = (r_state != StIdle);

endmodule

// File: tb/tb_incdec_arbiter.sv
// Directed and randomized checks of incdec_arbiter against a transaction-level model of
// the two counters, the carry flag and the round-robin preference.
module tb_incdec_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  incdec_arbiter_if #(.WIDTH(4)) bus ();

  incdec_arbiter #(.WIDTH(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Transaction-level model state.
  int m_q[2];
  int m_cout;
  int m_ptr;
  int m_op[2];
  int m_d[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    m_q[0] = 0;
    m_q[1] = 0;
    m_cout = 0;
    m_ptr  = 0;
  endfunction

  function automatic void model_apply(input int r);
    case (m_op[r])
      0: begin
        m_cout = (m_q[r] == 15) ? 1 : 0;
        m_q[r] = (m_q[r] + 1) % 16;
      end
      1: begin
        m_cout = (m_q[r] != 0) ? 1 : 0;
        m_q[r] = (m_q[r] + 15) % 16;
      end
      2: begin
        m_q[r] = m_d[r];
        m_cout = 0;
      end
      default: begin
        m_q[r] = 0;
        m_cout = 0;
      end
    endcase
    m_ptr = 1 - r;
  endfunction

  task automatic set_req(input int r, input bit v, input int op, input int d);
    m_op[r] = op;
    m_d[r]  = d;
    if (r == 0) begin
      bus.req0 = v;
      bus.op0  = 2'(op);
      bus.d0   = 4'(d);
    end else begin
      bus.req1 = v;
      bus.op1  = 2'(op);
      bus.d1   = 4'(d);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_q0"}, bus.q0, m_q[0]);
    check({tag, "_q1"}, bus.q1, m_q[1]);
    check({tag, "_cout"}, bus.cout, m_cout);
  endtask

  task automatic wait_ack(output int who, output int cyc);
    who = -1;
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      cyc++;
      if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) begin
        who = (bus.ack1 === 1'b1) ? 1 : 0;
        break;
      end
    end
    if (who < 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL wait_ack: got no ack expected one within 10 cycles");
    end
  endtask

  // One isolated operation from IDLE; optionally scrambles OP/D while busy.
  task automatic single_op(input int r, input int op, input int d, input bit scramble);
    set_req(r, 1'b1, op, d);
    tick();
    check("exec_busy", bus.busy, 1);
    check("exec_ack", {bus.ack1, bus.ack0}, 0);
    if (scramble) begin
      if (r == 0) begin
        bus.op0 = 2'($urandom_range(0, 3));
        bus.d0  = 4'($urandom_range(0, 15));
      end else begin
        bus.op1 = 2'($urandom_range(0, 3));
        bus.d1  = 4'($urandom_range(0, 15));
      end
    end
    tick();
    model_apply(r);
    check("resp_ack", {bus.ack1, bus.ack0}, (r == 1) ? 2 : 1);
    check("resp_gnt", bus.gnt, r);
    check("resp_busy", bus.busy, 1);
    check_regs("resp");
    if (r == 0) bus.req0 = 1'b0;
    else        bus.req1 = 1'b0;
    tick();
    check("idle_ack", {bus.ack1, bus.ack0}, 0);
    check("idle_busy", bus.busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int who;
    int cyc;
    int first;

    // Reset with random request activity.
    rst = 1'b1;
    bus.req0 = 1'($urandom_range(0, 1));
    bus.req1 = 1'($urandom_range(0, 1));
    bus.op0  = 2'($urandom_range(0, 3));
    bus.op1  = 2'($urandom_range(0, 3));
    bus.d0   = 4'($urandom_range(0, 15));
    bus.d1   = 4'($urandom_range(0, 15));
    tick();
    tick();
    check("rst_q0", bus.q0, 0);
    check("rst_q1", bus.q1, 0);
    check("rst_ack", {bus.ack1, bus.ack0}, 0);
    check("rst_cout", bus.cout, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_gnt", bus.gnt, 0);
    model_reset();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    rst = 1'b0;
    tick();

    // Increment wrap.
    single_op(0, 2, 15, 1'b0);
    single_op(0, 0, 0, 1'b0);
    check("incwrap_q0", bus.q0, 0);
    check("incwrap_cout", bus.cout, 1);
    check("incwrap_q1", bus.q1, 0);

    // Decrement boundary on requester 1.
    single_op(1, 1, 0, 1'b0);
    check("dec0_q1", bus.q1, 15);
    check("dec0_cout", bus.cout, 0);
    single_op(1, 1, 0, 1'b0);
    check("dec15_q1", bus.q1, 14);
    check("dec15_cout", bus.cout, 1);

    // Simultaneous continuous requests from reset alternate 0,1,0,1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    set_req(0, 1'b1, 0, 0);
    set_req(1, 1'b1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      wait_ack(who, cyc);
      check("sim_who", who, k % 2);
      check("sim_spacing", cyc, (k == 0) ? 2 : 3);
      if (who >= 0) model_apply(who);
      check_regs("sim");
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick();
    check("sim_q0", bus.q0, 2);
    check("sim_q1", bus.q1, 2);

    // Request 1 raised during requester 0's EXEC cycle.
    set_req(0, 1'b1, 0, 0);
    tick();
    set_req(1, 1'b1, 1, 0);
    wait_ack(who, cyc);
    check("late_first", who, 0);
    if (who >= 0) model_apply(who);
    check_regs("late_first");
    bus.req0 = 1'b0;
    wait_ack(who, cyc);
    check("late_second", who, 1);
    check("late_spacing", cyc, 3);
    if (who >= 0) model_apply(who);
    check_regs("late_second");
    bus.req1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("late_noack", {bus.ack1, bus.ack0}, 0);
    end
    check_regs("late_quiet");

    // Reset during EXEC abandons the operation.
    single_op(0, 2, 5, 1'b0);
    set_req(0, 1'b1, 0, 0);
    tick();
    rst = 1'b1;
    tick();
    check("midrst_ack", {bus.ack1, bus.ack0}, 0);
    check("midrst_q0", bus.q0, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_gnt", bus.gnt, 0);
    model_reset();
    rst = 1'b0;
    bus.req0 = 1'b0;
    tick();
    single_op(0, 0, 0, 1'b0);
    check("postrst_q0", bus.q0, 1);

    // Randomized single and contending operations.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        set_req(0, 1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
        set_req(1, 1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
        first = m_ptr;
        wait_ack(who, cyc);
        check("rnd_tie_who", who, first);
        if (who >= 0) model_apply(who);
        check_regs("rnd_tie1");
        if (first == 0) bus.req0 = 1'b0;
        else            bus.req1 = 1'b0;
        wait_ack(who, cyc);
        check("rnd_tie_next", who, 1 - first);
        check("rnd_tie_spacing", cyc, 3);
        if (who >= 0) model_apply(who);
        check_regs("rnd_tie2");
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
      end else begin
        single_op(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 15)), 1'b1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/incdec_arbiter.md
# incdec_arbiter

Two-requester controller that shares one 4-bit increment/decrement datapath between two independent counter registers. Each requester issues increment, decrement, load or clear operations on its own register through a REQ/ACK handshake. A round-robin arbiter grants the shared unit, and a 3-state sequencer runs each operation. It sits in front of the 4-bit inc/dec adder chain and owns the only copies of the two count registers.

## Interface
- WIDTH, 4, datapath and register width; the shared unit is the 4-bit inc/dec chain.
- CLK  in  1  single clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ0, REQ1  in  1  operation request from requester 0 / 1; level, held until ACK.
- OP0, OP1  in  2  opcode: 00 = inc, 01 = dec, 10 = load, 11 = clear; stable while REQn is high.
- D0, D1  in  WIDTH  load data; used only for opcode 10; stable while REQn is high.
- ACK0, ACK1  out  1  one-cycle completion pulse to requester 0 / 1.
- Q0, Q1  out  WIDTH  current count register of requester 0 / 1 (registered).
- COUT  out  1  carry/borrow-free flag of the last completed operation (registered).
- BUSY  out  1  high whenever the state is not IDLE.
- GNT  out  1  index of the requester being served; valid while BUSY, holds its last value otherwise.

## Operation
- Reset values: Q0 = Q1 = 0, ACK0 = ACK1 = 0, COUT = 0, BUSY = 0, GNT = 0, state IDLE, round-robin pointer set so requester 0 wins the first tie.
- FSM states and transitions:
  - IDLE: samples REQ0/REQ1. If either is high, pick a winner, latch its opcode, D and current Q into operand registers, set GNT, and go to EXEC. Otherwise stay in IDLE.
  - EXEC: apply the shared unit to the latched operand. Write the result into Q[GNT] and update COUT. Go to RESP.
  - RESP: ACK[GNT] = 1 for exactly this cycle. Update the pointer to favour the other requester. Go to IDLE.
- Arbitration:
  - Only one REQ high: that requester wins.
  - Both high: the requester not served last wins.
  - The pointer changes only in RESP.
- Arithmetic (mod 2^WIDTH):
  - inc: Q+1. COUT = 1 only when Q was 15, so 15 wraps to 0.
  - dec: Q + 1111 (two's-complement add of all-ones). COUT = carry-out, i.e. 1 unless Q was 0; 0 wraps to 15 with COUT = 0.
  - load: Q = D, COUT = 0.
  - clear: Q = 0, COUT = 0.
- The non-granted register is never modified.
- REQ is sampled only in IDLE. Requests raised during EXEC/RESP wait; no request is dropped.
- Handshake: a requester must hold REQ/OP/D until it sees ACK. If REQ is still high in the IDLE cycle after ACK, that is a new request and the same operation is executed again.
- OP/D changes while BUSY for the granted requester are ignored, because they were latched in IDLE.
- RST high in any state, including mid-operation:
  - abandons the operation; no ACK is issued;
  - all registers return to their reset values on that edge.

## Timing
- Latency: REQn sampled high at edge t0 (IDLE).
  - At edge t1 (EXEC→RESP), Qn and COUT update and ACKn goes high.
  - At edge t2, ACKn returns low and the state returns to IDLE.
- Throughput: one operation per 3 cycles with REQ held continuously. Two continuously requesting masters alternate 0,1,0,1…
- Qn is valid with its new value in the same cycle ACKn is high.
- BUSY is high from the cycle after t0 through the ACK cycle inclusive.
- No combinational path from inputs to outputs; all outputs are registers.

## Test plan
- Reset: drive RST for 2 cycles with random REQ/OP -> Q0 = Q1 = 0, ACK0 = ACK1 = 0, COUT = 0, BUSY = 0, GNT = 0.
- Increment wrap: load Q0 = 15 (OP0 = 10, D0 = 1111), then inc -> Q0 = 0, COUT = 1; ACK0 pulses 2 cycles after each REQ sample, 1 cycle wide; Q1 unchanged.
- Decrement boundary: requester 1 with Q1 = 0 dec -> Q1 = 15, COUT = 0. Then dec again -> Q1 = 14, COUT = 1.
- Simultaneous requests: REQ0 = REQ1 = 1 held, both inc, from reset -> grant order 0,1,0,1. After 4 ACKs, Q0 = 2 and Q1 = 2, with ACKs 3 cycles apart.
- Late request: raise REQ1 during requester 0's EXEC cycle -> REQ1 is served immediately after RESP; no ACK lost, no double execution.
- Reset mid-operation: REQ0 inc with Q0 = 5, assert RST in EXEC -> no ACK0, Q0 = 0, state IDLE. The next request completes normally.
